// File: rtl/katana_tracker_if.sv
// Pixel-stream / marker-result bundle between a camera front end and katana_tracker.
// The master drives raster position and pixel; the slave returns the centroid.
interface katana_tracker_if;
   logic [10:0] hcount_in;
   logic [9:0]  vcount_in;
   logic [11:0] pixel_in;
   logic [10:0] katana_x;
   logic [9:0]  katana_y;
   logic        pos_valid_out;
   logic        detected_out;

   modport master (
      output hcount_in, vcount_in, pixel_in,
      input  katana_x, katana_y, pos_valid_out, detected_out
   );

   modport slave (
      input  hcount_in, vcount_in, pixel_in,
      output katana_x, katana_y, pos_valid_out, detected_out
   );
endinterface

// File: rtl/katana_tracker.sv
// Green-marker centroid tracker: accumulates matching pixels per frame, then runs two
// serial restoring dividers (30 cycles) to produce the centroid one cycle later.
module katana_tracker #(
   parameter logic [3:0] G_MIN     = 4'hA,
   parameter logic [3:0] R_MAX     = 4'h5,
   parameter logic [3:0] B_MAX     = 4'h5,
   parameter int         MIN_COUNT = 64
) (
   input logic             clk_in,
   input logic             rst_in,
   katana_tracker_if.slave bus
);

   localparam logic [1:0]  S_IDLE      = 2'd0;
   localparam logic [1:0]  S_DIVIDE    = 2'd1;
   localparam logic [1:0]  S_UPDATE    = 2'd2;
   localparam logic [4:0]  L_LAST_STEP = 5'd29;
   localparam logic [19:0] L_MIN_COUNT = 20'(MIN_COUNT);

   logic [19:0] r_count;
   logic [29:0] r_sum_x;
   logic [29:0] r_sum_y;

   logic [1:0]  r_state;
   logic [4:0]  r_step;
   logic [19:0] r_den;
   logic [29:0] r_quo_x;
   logic [29:0] r_quo_y;
   logic [19:0] r_rem_x;
   logic [19:0] r_rem_y;

   logic [10:0] r_katana_x;
   logic [9:0]  r_katana_y;
   logic        r_pos_valid;
   logic        r_detected;

   logic        w_active;
   logic        w_match;
   logic        w_frame_end;
   logic [20:0] w_trial_x;
   logic [20:0] w_trial_y;
   logic [20:0] w_diff_x;
   logic [20:0] w_diff_y;
   logic        w_ge_x;
   logic        w_ge_y;

   assign w_active    = (bus.hcount_in < 11'd1024) && (bus.vcount_in < 10'd768);
   assign w_match     = (bus.pixel_in[7:4] >= G_MIN) &&
                        (bus.pixel_in[11:8] <= R_MAX) &&
                        (bus.pixel_in[3:0] <= B_MAX);
   assign w_frame_end = (bus.hcount_in == 11'd1024) && (bus.vcount_in == 10'd768);

   // Restoring step: bring down the next dividend bit; subtract only if it fits.
   assign w_trial_x = {r_rem_x, r_quo_x[29]};
   assign w_trial_y = {r_rem_y, r_quo_y[29]};
   assign w_diff_x  = w_trial_x - {1'b0, r_den};
   assign w_diff_y  = w_trial_y - {1'b0, r_den};
   assign w_ge_x    = (w_trial_x >= {1'b0, r_den});
   assign w_ge_y    = (w_trial_y >= {1'b0, r_den});

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values; blocking here would create order-dependent simulation races.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_count <= '0;
         r_sum_x <= '0;
         r_sum_y <= '0;
      end else if (w_frame_end) begin
         r_count <= '0;
         r_sum_x <= '0;
         r_sum_y <= '0;
      end else if (w_active && w_match) begin
         r_count <= r_count + 20'd1;
         r_sum_x <= r_sum_x + 30'(bus.hcount_in);
         r_sum_y <= r_sum_y + 30'(bus.vcount_in);
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state     <= S_IDLE;
         r_step      <= '0;
         r_den       <= '0;
         r_quo_x     <= '0;
         r_quo_y     <= '0;
         r_rem_x     <= '0;
         r_rem_y     <= '0;
         r_katana_x  <= 11'd512;
         r_katana_y  <= 10'd384;
         r_pos_valid <= 1'b0;
         r_detected  <= 1'b0;
      end else begin
         r_pos_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_frame_end) begin
                  r_den   <= r_count;
                  r_quo_x <= r_sum_x;
                  r_quo_y <= r_sum_y;
                  r_rem_x <= '0;
                  r_rem_y <= '0;
                  r_step  <= '0;
                  r_state <= S_DIVIDE;
               end
            end
            S_DIVIDE: begin
               r_rem_x <= w_ge_x ? w_diff_x[19:0] : w_trial_x[19:0];
               r_rem_y <= w_ge_y ? w_diff_y[19:0] : w_trial_y[19:0];
               r_quo_x <= {r_quo_x[28:0], w_ge_x};
               r_quo_y <= {r_quo_y[28:0], w_ge_y};
               r_step  <= r_step + 5'd1;
               if (r_step == L_LAST_STEP) begin
                  r_state <= S_UPDATE;
               end
            end
            S_UPDATE: begin
               r_pos_valid <= 1'b1;
               // Too few pixels (including zero): the quotient is meaningless, keep old position.
               if (r_den >= L_MIN_COUNT) begin
                  r_katana_x <= r_quo_x[10:0];
                  r_katana_y <= r_quo_y[9:0];
                  r_detected <= 1'b1;
               end else begin
                  r_detected <= 1'b0;
               end
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.katana_x      = r_katana_x;
   assign bus.katana_y      = r_katana_y;
   assign bus.pos_valid_out = r_pos_valid;
   assign bus.detected_out  = r_detected;

endmodule

// File: tb/tb_katana_tracker.sv
// Directed bench for katana_tracker: marker scenes fed as sparse pixel sequences,
// with exact pulse timing and centroid values computed by hand.
module tb_katana_tracker;

   logic clk_in = 1'b0;
   logic rst_in;
   int   checks = 0;
   int   errors = 0;

   always #5 clk_in = ~clk_in;

   katana_tracker_if bus ();

   katana_tracker #(
      .G_MIN     (4'hA),
      .R_MAX     (4'h5),
      .B_MAX     (4'h5),
      .MIN_COUNT (64)
   ) dut (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .bus    (bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One pixel per clock: inputs are held for exactly one sampling edge, then #1 to read.
   task automatic step(input logic [10:0] h, input logic [9:0] v, input logic [11:0] p);
      bus.hcount_in = h;
      bus.vcount_in = v;
      bus.pixel_in  = p;
      @(posedge clk_in);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(11'd1100, 10'd800, 12'h000);
   endtask

   task automatic frame_end();
      step(11'd1024, 10'd768, 12'h000);
   endtask

   task automatic block(input int x0, input int y0, input logic [11:0] pix, input bit hole);
      for (int dy = 0; dy < 8; dy++)
         for (int dx = 0; dx < 8; dx++)
            step(11'(x0 + dx), 10'(y0 + dy), (hole && dx == 7 && dy == 7) ? 12'h000 : pix);
   endtask

   task automatic do_reset();
      rst_in = 1'b1;
      idle(2);
      rst_in = 1'b0;
   endtask

   // Pulse must appear in cycle N+32; 'elapsed' counts steps already taken since frame end.
   task automatic expect_pulse(input string tag, input int elapsed, input int ex, input int ey,
                               input bit edet);
      idle(30 - elapsed);
      check({tag, "_early"}, bus.pos_valid_out, 0);
      idle(1);
      check({tag, "_pulse"}, bus.pos_valid_out, 1);
      check({tag, "_x"}, bus.katana_x, ex);
      check({tag, "_y"}, bus.katana_y, ey);
      check({tag, "_det"}, bus.detected_out, edet);
      idle(1);
      check({tag, "_one_cycle"}, bus.pos_valid_out, 0);
   endtask

   task automatic no_pulse(input string tag, input int n);
      logic seen = 1'b0;
      for (int i = 0; i < n; i++) begin
         idle(1);
         seen = seen | bus.pos_valid_out;
      end
      check(tag, seen, 0);
   endtask

   initial begin
      bus.hcount_in = 11'd1100;
      bus.vcount_in = 10'd800;
      bus.pixel_in  = 12'h000;
      rst_in        = 1'b1;
      do_reset();
      check("rst_x", bus.katana_x, 512);
      check("rst_y", bus.katana_y, 384);
      check("rst_pv", bus.pos_valid_out, 0);
      check("rst_det", bus.detected_out, 0);

      // 64 green pixels at x 100..107, y 200..207
      block(100, 200, 12'h0F0, 1'b0);
      frame_end();
      expect_pulse("blk", 0, 103, 203, 1'b1);

      // 63 matches: below threshold, position reverts to nothing new
      do_reset();
      block(100, 200, 12'h0F0, 1'b1);
      frame_end();
      expect_pulse("thin", 0, 512, 384, 1'b0);

      // Inclusive thresholds; near-miss colours and off-screen greens must not shift the centroid
      block(100, 200, 12'h5A5, 1'b0);
      for (int i = 0; i < 8; i++) begin
         step(11'd900, 10'd700, 12'h6A5);
         step(11'd900, 10'd700, 12'h095);
         step(11'd900, 10'd700, 12'h0A6);
      end
      for (int h = 1024; h < 1344; h++) step(11'(h), 10'd10, 12'h0F0);
      for (int v = 768; v < 806; v++) step(11'd10, 10'(v), 12'h0F0);
      frame_end();
      expect_pulse("thr", 0, 103, 203, 1'b1);

      // Reset at N+10 aborts the computation
      block(300, 100, 12'h0F0, 1'b0);
      frame_end();
      idle(9);
      rst_in = 1'b1;
      idle(1);
      rst_in = 1'b0;
      no_pulse("abort_no_pulse", 40);
      check("abort_x", bus.katana_x, 512);
      check("abort_y", bus.katana_y, 384);
      check("abort_det", bus.detected_out, 0);
      block(100, 200, 12'h0F0, 1'b0);
      frame_end();
      expect_pulse("post_rst", 0, 103, 203, 1'b1);

      // Two consecutive frames, no carry-over
      block(297, 97, 12'h0F0, 1'b0);
      frame_end();
      expect_pulse("f1", 0, 300, 100, 1'b1);
      block(697, 597, 12'h0F0, 1'b0);
      frame_end();
      expect_pulse("f2", 0, 700, 600, 1'b1);

      // Frame end during DIVIDE: ignored for division, but its pixels are discarded
      block(100, 200, 12'h0F0, 1'b0);
      frame_end();
      for (int i = 0; i < 8; i++) step(11'd900, 10'(i), 12'h0F0);
      frame_end();
      expect_pulse("busy", 9, 103, 203, 1'b1);
      no_pulse("busy_ignored", 40);
      block(697, 597, 12'h0F0, 1'b0);
      frame_end();
      expect_pulse("after_busy", 0, 700, 600, 1'b1);

      // Empty frame: count 0, position held
      frame_end();
      expect_pulse("empty", 0, 700, 600, 1'b0);

      // 40 full-width rows 728..767: count 40960, large sums
      for (int v = 728; v < 768; v++)
         for (int h = 0; h < 1024; h++)
            step(11'(h), 10'(v), 12'h0F0);
      frame_end();
      expect_pulse("wide", 0, 511, 747, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
